adc_emulator: RTL and testbench

Synthesizable device-side model of the 6-channel, 18-bit dual-serial-line ADC that adc_controller drives. It responds to convst, holds busy for an oversampling-dependent conversion time, and shifts out channel data on data_a/data_b under n_cs/sclk. It is used for on-FPGA loopback and hardware-in-loop testing of adc_controller without a physical ADC. Channel values are host-programmable.

---
 rtl/adc_emulator.sv | 185 ++++++++++++++++++
 tb/tb_adc_emulator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_emulator.sv
// Device-side emulation of a 6-channel, 18-bit dual-line serial ADC used for controller loopback tests.
// Optional macro ADC_EMU_RAMP_EN adds a per-conversion ramp value to every latched frame.
module adc_emulator #(
    parameter int W_DATA = 18,
    parameter int N_CHAN = 6,
    parameter int T_CONV = 8,
    parameter int W_CNT  = 12
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              adc_reset_in,
    input  logic              convst_in,
    input  logic [2:0]        os_in,
    input  logic              n_cs_in,
    input  logic              sclk_in,
    input  logic              chan_wr_in,
    input  logic [2:0]        chan_addr_in,
    input  logic [W_DATA-1:0] chan_data_in,
    output logic              busy_out,
    output logic              data_a_out,
    output logic              data_b_out,
    output logic              conv_done_out
);
    localparam int N_HALF  = N_CHAN / 2;
    localparam int W_SHIFT = N_HALF * W_DATA;
    localparam int W_SCNT  = $clog2(W_SHIFT + 1);

    typedef enum logic {ST_IDLE, ST_CONV} state_t;

    state_t             state_q;
    logic [W_CNT-1:0]   cnt_q;
    logic               busy_q;
    logic               conv_done_q;
    logic               convst_prev_q;
    logic               ncs_prev_q;
    logic               sclk_prev_q;
    logic [W_SHIFT-1:0] shift_a_q;
    logic [W_SHIFT-1:0] shift_b_q;
    logic [W_SCNT-1:0]  scnt_q;

    logic               convst_rise;
    logic               ncs_fall;
    logic               sclk_fall;
    logic               latch_now;
    logic [2:0]         os_eff;
    logic [W_CNT-1:0]   conv_len;
    logic [W_DATA-1:0]  ramp_val;
    logic [W_DATA-1:0]  frame_src [N_CHAN];
    logic [W_SHIFT-1:0] load_a;
    logic [W_SHIFT-1:0] load_b;

    assign convst_rise = convst_in & ~convst_prev_q;
    assign ncs_fall    = ~n_cs_in & ncs_prev_q;
    assign sclk_fall   = ~sclk_in & sclk_prev_q;
    assign os_eff      = (os_in == 3'd7) ? 3'd0 : os_in;
    assign conv_len    = W_CNT'(T_CONV) << os_eff;
    assign latch_now   = (state_q == ST_CONV) && (cnt_q == W_CNT'(1)) && !adc_reset_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            convst_prev_q <= 1'b0;
            ncs_prev_q    <= 1'b1;
            sclk_prev_q   <= 1'b1;
        end else begin
            convst_prev_q <= convst_in;
            ncs_prev_q    <= n_cs_in;
            sclk_prev_q   <= sclk_in;
        end
    end

`ifdef ADC_EMU_RAMP_EN
    logic [W_DATA-1:0] ramp_q;

    always_ff @(posedge clk_in) begin
        if (reset_in || adc_reset_in) begin
            ramp_q <= '0;
        end else if (latch_now) begin
            ramp_q <= ramp_q + W_DATA'(1);
        end
    end

    assign ramp_val = ramp_q;
`else
    assign ramp_val = '0;
`endif

    // Host writes land in chan_q at once but reach the serial lines only via the frame latch.
    genvar gi;
    for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
        logic [W_DATA-1:0] chan_q;
        logic [W_DATA-1:0] frame_q;
        logic [W_DATA-1:0] frame_d;

        assign frame_d = chan_q + ramp_val;

        always_ff @(posedge clk_in) begin
            if (reset_in) begin
                chan_q  <= '0;
                frame_q <= '0;
            end else begin
                if (chan_wr_in && (chan_addr_in == 3'(gi))) begin
                    chan_q <= chan_data_in;
                end
                if (latch_now) begin
                    frame_q <= frame_d;
                end
            end
        end

        // A chip-select fall coinciding with the latch must see the new frame.
        assign frame_src[gi] = latch_now ? frame_d : frame_q;
    end

    always_comb begin
        load_a = '0;
        load_b = '0;
        for (int i = 0; i < N_HALF; i++) begin
            load_a[(N_HALF-1-i)*W_DATA +: W_DATA] = frame_src[i];
            load_b[(N_HALF-1-i)*W_DATA +: W_DATA] = frame_src[i+N_HALF];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            conv_done_q <= 1'b0;
        end else begin
            conv_done_q <= 1'b0;
            if (adc_reset_in) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (convst_rise) begin
                            state_q <= ST_CONV;
                            cnt_q   <= conv_len;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_CONV: begin
                        if (cnt_q == W_CNT'(1)) begin
                            state_q     <= ST_IDLE;
                            cnt_q       <= '0;
                            busy_q      <= 1'b0;
                            conv_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - W_CNT'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Zero fill means the lines naturally idle low once the whole frame has been shifted out.
    always_ff @(posedge clk_in) begin
        if (reset_in || adc_reset_in || n_cs_in) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
            scnt_q    <= '0;
        end else if (ncs_fall) begin
            shift_a_q <= load_a;
            shift_b_q <= load_b;
            scnt_q    <= '0;
        end else if (sclk_fall && (scnt_q < W_SCNT'(W_SHIFT))) begin
            shift_a_q <= {shift_a_q[W_SHIFT-2:0], 1'b0};
            shift_b_q <= {shift_b_q[W_SHIFT-2:0], 1'b0};
            scnt_q    <= scnt_q + W_SCNT'(1);
        end
    end

    assign busy_out      = busy_q;
    assign conv_done_out = conv_done_q;
    assign data_a_out    = shift_a_q[W_SHIFT-1];
    assign data_b_out    = shift_b_q[W_SHIFT-1];

endmodule

// File: tb/tb_adc_emulator.sv
// Self-checking bench for adc_emulator: per-cycle behavioural model plus directed frame/timing checks.
module tb_adc_emulator;
`ifdef ADC_EMU_RAMP_EN
    localparam int RAMP = 1;
`else
    localparam int RAMP = 0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        adc_reset_in;
    logic        convst_in;
    logic [2:0]  os_in;
    logic        n_cs_in;
    logic        sclk_in;
    logic        chan_wr_in;
    logic [2:0]  chan_addr_in;
    logic [17:0] chan_data_in;
    logic        busy_out;
    logic        data_a_out;
    logic        data_b_out;
    logic        conv_done_out;

    int total = 0;
    int bad   = 0;

    adc_emulator dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .adc_reset_in  (adc_reset_in),
        .convst_in     (convst_in),
        .os_in         (os_in),
        .n_cs_in       (n_cs_in),
        .sclk_in       (sclk_in),
        .chan_wr_in    (chan_wr_in),
        .chan_addr_in  (chan_addr_in),
        .chan_data_in  (chan_data_in),
        .busy_out      (busy_out),
        .data_a_out    (data_a_out),
        .data_b_out    (data_b_out),
        .conv_done_out (conv_done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [17:0] m_chan [6];
    logic [17:0] m_frame [6];
    logic [53:0] m_vec_a = '0;
    logic [53:0] m_vec_b = '0;
    int          m_pos   = -1;
    int          m_rem   = 0;
    int          m_ramp  = 0;
    bit          m_busy  = 0;
    bit          m_done  = 0;
    bit          m_latch;
    bit          p_conv  = 0;
    bit          p_ncs   = 1;
    bit          p_sclk  = 1;

    initial begin
        for (int i = 0; i < 6; i++) begin
            m_chan[i]  = '0;
            m_frame[i] = '0;
        end
    end

    always @(negedge clk_in) begin
        chk("busy", busy_out, m_busy);
        chk("done", conv_done_out, m_done);
        chk("data_a", data_a_out, (m_pos >= 0 && m_pos < 54) ? m_vec_a[53-m_pos] : 1'b0);
        chk("data_b", data_b_out, (m_pos >= 0 && m_pos < 54) ? m_vec_b[53-m_pos] : 1'b0);

        if (reset_in) begin
            for (int i = 0; i < 6; i++) begin
                m_chan[i]  = '0;
                m_frame[i] = '0;
            end
            m_pos  = -1;
            m_rem  = 0;
            m_ramp = 0;
            m_busy = 0;
            m_done = 0;
            p_conv = 0;
            p_ncs  = 1;
            p_sclk = 1;
        end else begin
            m_latch = (m_rem == 1) && !adc_reset_in;
            m_done  = m_latch;
            if (adc_reset_in)
                m_rem = 0;
            else if (m_rem > 0)
                m_rem--;
            else if (convst_in && !p_conv)
                m_rem = 8 << ((os_in == 3'd7) ? 0 : int'(os_in));
            m_busy = (m_rem > 0);

            if (m_latch) begin
                for (int i = 0; i < 6; i++) m_frame[i] = m_chan[i] + 18'(m_ramp * RAMP);
                m_ramp++;
            end
            if (adc_reset_in) m_ramp = 0;

            if (adc_reset_in || n_cs_in) begin
                m_pos = -1;
            end else if (p_ncs) begin
                m_vec_a = {m_frame[0], m_frame[1], m_frame[2]};
                m_vec_b = {m_frame[3], m_frame[4], m_frame[5]};
                m_pos   = 0;
            end else if (p_sclk && !sclk_in && m_pos >= 0 && m_pos < 54) begin
                m_pos++;
            end

            if (chan_wr_in && chan_addr_in < 3'd6) m_chan[chan_addr_in] = chan_data_in;

            p_conv = convst_in;
            p_ncs  = n_cs_in;
            p_sclk = sclk_in;
        end
    end

    // ---------------- directed stimulus ----------------
    logic [53:0] rd_a;
    logic [53:0] rd_b;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [17:0] rv(input int base, input int off);
        return 18'(base + RAMP * off);
    endfunction

    task automatic wr(input int addr, input int data);
        chan_wr_in   = 1'b1;
        chan_addr_in = 3'(addr);
        chan_data_in = 18'(data);
        tick();
        chan_wr_in   = 1'b0;
        $display("write addr=%0d data=%0d", addr, data);
    endtask

    // rp: convst re-pulse cycle, ar: adc_reset cycle, nc: n_cs drop cycle (0 = none)
    task automatic run_conv(input int os, input int rp, input int ar, input int nc,
                            input int exp_b, input int exp_d, input string nm);
        int nb;
        int nd;
        nb = 0;
        nd = 0;
        os_in     = 3'(os);
        convst_in = 1'b1;
        tick();
        convst_in = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            nb += int'(busy_out);
            nd += int'(conv_done_out);
            convst_in    = (k == rp);
            adc_reset_in = (k == ar);
            if (nc > 0 && k == nc) n_cs_in = 1'b0;
            tick();
        end
        convst_in    = 1'b0;
        adc_reset_in = 1'b0;
        chk({nm, "_busy_len"}, nb, exp_b);
        chk({nm, "_done_cnt"}, nd, exp_d);
        $display("conv %s os=%0d busy_cycles=%0d done_pulses=%0d", nm, os, nb, nd);
    endtask

    task automatic read_frame(input bit do_fall, input int wr_bit, input int nbits,
                              output logic [53:0] a, output logic [53:0] b);
        a = '0;
        b = '0;
        if (do_fall) begin
            n_cs_in = 1'b0;
            tick();
        end
        for (int i = 0; i < nbits; i++) begin
            a[53-i] = data_a_out;
            b[53-i] = data_b_out;
            if (i == wr_bit) begin
                chan_wr_in   = 1'b1;
                chan_addr_in = 3'd2;
                chan_data_in = 18'd9999;
            end
            sclk_in = 1'b0;
            tick();
            chan_wr_in = 1'b0;
            sclk_in    = 1'b1;
            tick();
        end
        if (nbits == 54) begin
            chk("tail_a", data_a_out, 1'b0);
            chk("tail_b", data_b_out, 1'b0);
        end
        n_cs_in = 1'b1;
        tick();
        tick();
        $display("read bits=%0d a=%h b=%h", nbits, a, b);
    endtask

    task automatic chk_frame(input string nm, input logic [53:0] a, input logic [53:0] b,
                             input int v0, input int v1, input int v2,
                             input int v3, input int v4, input int v5, input int off);
        chk({nm, "_ch0"}, a[53:36], rv(v0, off));
        chk({nm, "_ch1"}, a[35:18], rv(v1, off));
        chk({nm, "_ch2"}, a[17:0],  rv(v2, off));
        chk({nm, "_ch3"}, b[53:36], rv(v3, off));
        chk({nm, "_ch4"}, b[35:18], rv(v4, off));
        chk({nm, "_ch5"}, b[17:0],  rv(v5, off));
    endtask

    initial begin
        reset_in     = 1'b1;
        adc_reset_in = 1'b0;
        convst_in    = 1'b0;
        os_in        = 3'd0;
        n_cs_in      = 1'b1;
        sclk_in      = 1'b1;
        chan_wr_in   = 1'b0;
        chan_addr_in = 3'd0;
        chan_data_in = '0;
        repeat (3) tick();
        reset_in = 1'b0;
        tick();
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_done", conv_done_out, 1'b0);
        chk("rst_a", data_a_out, 1'b0);
        chk("rst_b", data_b_out, 1'b0);

        for (int i = 0; i < 6; i++) wr(i, 1111 * (i + 1));
        wr(6, 12345);
        wr(7, 54321);

        run_conv(0, 0, 0, 0, 8, 1, "os0");
        read_frame(1, -1, 54, rd_a, rd_b);
        chk_frame("rd1", rd_a, rd_b, 1111, 2222, 3333, 4444, 5555, 6666, 0);

        run_conv(2, 0, 0, 0, 32, 1, "os2");
        read_frame(1, -1, 54, rd_a, rd_b);
        chk_frame("rd2", rd_a, rd_b, 1111, 2222, 3333, 4444, 5555, 6666, 1);

        run_conv(7, 0, 0, 0, 8, 1, "os7");
        read_frame(1, -1, 54, rd_a, rd_b);
        chk_frame("rd3", rd_a, rd_b, 1111, 2222, 3333, 4444, 5555, 6666, 2);

        run_conv(0, 5, 0, 0, 8, 1, "repulse");

        // aborted read followed by a full read that writes ch2 mid-frame
        read_frame(1, -1, 20, rd_a, rd_b);
        chk("abort_ch0", rd_a[53:36], rv(1111, 3));
        read_frame(1, 30, 54, rd_a, rd_b);
        chk_frame("rd4", rd_a, rd_b, 1111, 2222, 3333, 4444, 5555, 6666, 3);
        read_frame(1, -1, 54, rd_a, rd_b);
        chk_frame("rd5", rd_a, rd_b, 1111, 2222, 3333, 4444, 5555, 6666, 3);

        run_conv(0, 0, 3, 0, 3, 0, "adcrst");
        read_frame(1, -1, 54, rd_a, rd_b);
        chk_frame("rd6", rd_a, rd_b, 1111, 2222, 3333, 4444, 5555, 6666, 3);

        // n_cs falls in the latch cycle: the new frame must be shifted out
        wr(0, 262143);
        run_conv(0, 0, 0, 8, 8, 1, "bypass");
        read_frame(0, -1, 54, rd_a, rd_b);
        chk_frame("rd7", rd_a, rd_b, 262143, 2222, 9999, 4444, 5555, 6666, 0);

        run_conv(0, 0, 0, 0, 8, 1, "wrap");
        read_frame(1, -1, 54, rd_a, rd_b);
        chk_frame("rd8", rd_a, rd_b, 262143, 2222, 9999, 4444, 5555, 6666, 1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
